// File: rtl/trap_ctrl_if.sv
// -----------------------------------------------------------------------------
// trap_ctrl_if
//   Bundles the EX-stage event inputs, CSR inputs and redirect outputs of the
//   trap controller.
//   master : pipeline side. Drives the i_* signals and observes the o_* signals.
//   slave  : trap_ctrl side.
//
//   i_ex_valid/i_ex_pc     valid instruction in EX and its PC
//   i_stall                pipeline stall; blocks trap/mret acceptance
//   i_ecall/i_ebreak/
//   i_illegal/i_mret       EX instruction class
//   i_irq/i_mie_en         pending interrupt lines and per-line enables
//   i_mtvec                trap vector CSR ([1:0] mode, [31:2] base)
//   i_mstatus_wr/_mie      CSR write strobe and data for mstatus.MIE
//   o_pc_src               00 RESET, 01 TRAP, 10 EPC, 11 NEXT
//   o_pc_trap/o_mepc/
//   o_mcause/o_mie         trap target, saved PC, cause, mstatus.MIE
//   o_flush/o_trap_taken   pipeline flush, one-cycle trap-entry pulse
// -----------------------------------------------------------------------------
interface trap_ctrl_if #(
  parameter int IRQ_W = 3
);
  logic             i_ex_valid;
  logic [31:0]      i_ex_pc;
  logic             i_stall;
  logic             i_ecall;
  logic             i_ebreak;
  logic             i_illegal;
  logic             i_mret;
  logic [IRQ_W-1:0] i_irq;
  logic [IRQ_W-1:0] i_mie_en;
  logic [31:0]      i_mtvec;
  logic             i_mstatus_wr;
  logic             i_mstatus_mie;
  logic [1:0]       o_pc_src;
  logic [31:0]      o_pc_trap;
  logic [31:0]      o_mepc;
  logic [31:0]      o_mcause;
  logic             o_mie;
  logic             o_flush;
  logic             o_trap_taken;

  modport master (
    output i_ex_valid, i_ex_pc, i_stall, i_ecall, i_ebreak, i_illegal, i_mret,
           i_irq, i_mie_en, i_mtvec, i_mstatus_wr, i_mstatus_mie,
    input  o_pc_src, o_pc_trap, o_mepc, o_mcause, o_mie, o_flush, o_trap_taken
  );

  modport slave (
    input  i_ex_valid, i_ex_pc, i_stall, i_ecall, i_ebreak, i_illegal, i_mret,
           i_irq, i_mie_en, i_mtvec, i_mstatus_wr, i_mstatus_mie,
    output o_pc_src, o_pc_trap, o_mepc, o_mcause, o_mie, o_flush, o_trap_taken
  );
endinterface

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
//   Control stage ahead of the next-PC selector. Samples exceptions, mret and
//   pending interrupts against the EX instruction, owns mepc/mcause/MIE/MPIE
//   and produces a registered PC source select plus pipeline flush.
//
//   Ports
//     i_clk    clock, rising edge
//     i_rst_n  asynchronous active-low reset
//     bus      trap_ctrl_if.slave (event inputs, CSR inputs, redirect outputs)
//
//   Parameters
//     RESET_VEC  value of o_pc_trap while held in reset
//     IRQ_W      interrupt line count: bit0 software, bit1 timer, bit2 external
//
//   Build option
//     TRAP_VECTORED_EN  when defined, interrupts with mtvec mode 01 jump to
//                       base + 4*cause; otherwise every trap jumps to base.
// -----------------------------------------------------------------------------
module trap_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          IRQ_W     = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  trap_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_RUN  = 2'd1,
    S_TRAP = 2'd2,
    S_RET  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PC_RESET = 2'b00,
    PC_TRAP  = 2'b01,
    PC_EPC   = 2'b10,
    PC_NEXT  = 2'b11
  } pc_src_e;

  localparam int IRQ_SW  = 0;
  localparam int IRQ_TMR = 1;
  localparam int IRQ_EXT = 2;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] CAUSE_IRQ_SW  = 32'h8000_0003;
  localparam logic [31:0] CAUSE_IRQ_TMR = 32'h8000_0007;
  localparam logic [31:0] CAUSE_IRQ_EXT = 32'h8000_000B;

  state_e      state_q;
  pc_src_e     pc_src_q;
  logic [31:0] pc_trap_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic        mie_q;
  logic        mpie_q;
  logic        flush_q;
  logic        trap_taken_q;

  // Event decode for the current EX instruction
  logic             accept;
  logic [IRQ_W-1:0] irq_pend;
  logic             irq_take;
  logic             take_trap;
  logic             take_mret;
  logic [31:0]      cause;
  logic [31:0]      trap_base;
  logic [31:0]      trap_target;

  assign accept    = (state_q == S_RUN) && bus.i_ex_valid && !bus.i_stall;
  assign irq_pend  = bus.i_irq & bus.i_mie_en;
  assign irq_take  = mie_q && (irq_pend != '0);
  assign trap_base = {bus.i_mtvec[31:2], 2'b00};

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    take_trap = 1'b0;
    take_mret = 1'b0;
    cause     = '0;
    if (accept) begin
      if (bus.i_illegal) begin
        take_trap = 1'b1;
        cause     = CAUSE_ILLEGAL;
      end else if (bus.i_ebreak) begin
        take_trap = 1'b1;
        cause     = CAUSE_EBREAK;
      end else if (bus.i_ecall) begin
        take_trap = 1'b1;
        cause     = CAUSE_ECALL;
      end else if (irq_take) begin
        // An interrupt also pre-empts an mret in EX; mepc then holds the mret PC
        take_trap = 1'b1;
        if (irq_pend[IRQ_EXT])     cause = CAUSE_IRQ_EXT;
        else if (irq_pend[IRQ_SW]) cause = CAUSE_IRQ_SW;
        else                       cause = CAUSE_IRQ_TMR;
      end else if (bus.i_mret) begin
        take_mret = 1'b1;
      end
    end
  end

`ifdef TRAP_VECTORED_EN
  always_comb begin
    trap_target = trap_base;
    if ((bus.i_mtvec[1:0] == 2'b01) && cause[31]) begin
      trap_target = trap_base + {25'd0, cause[4:0], 2'b00};
    end
  end
`else
  // Mode bits have no effect in this build
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^bus.i_mtvec[1:0];
  assign trap_target       = trap_base;
`endif

  // NOTE: state and CSR registers use non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_RST;
      pc_src_q     <= PC_RESET;
      pc_trap_q    <= RESET_VEC;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mie_q        <= 1'b0;
      mpie_q       <= 1'b0;
      flush_q      <= 1'b0;
      trap_taken_q <= 1'b0;
    end else begin
      case (state_q)
        S_RST: begin
          state_q      <= S_RUN;
          pc_src_q     <= PC_NEXT;
          flush_q      <= 1'b0;
          trap_taken_q <= 1'b0;
        end

        S_RUN: begin
          if (take_trap) begin
            state_q      <= S_TRAP;
            pc_src_q     <= PC_TRAP;
            pc_trap_q    <= trap_target;
            mepc_q       <= bus.i_ex_pc;
            mcause_q     <= cause;
            mpie_q       <= mie_q;
            mie_q        <= 1'b0;
            flush_q      <= 1'b1;
            trap_taken_q <= 1'b1;
          end else if (take_mret) begin
            state_q      <= S_RET;
            pc_src_q     <= PC_EPC;
            mie_q        <= mpie_q;
            mpie_q       <= 1'b1;
            flush_q      <= 1'b1;
            trap_taken_q <= 1'b0;
          end else begin
            // A CSR write only lands when no trap/mret claims MIE this cycle
            if (bus.i_mstatus_wr) begin
              mie_q <= bus.i_mstatus_mie;
            end
            pc_src_q     <= PC_NEXT;
            flush_q      <= 1'b0;
            trap_taken_q <= 1'b0;
          end
        end

        // Redirect cycles last one clock and ignore all events
        S_TRAP, S_RET: begin
          state_q      <= S_RUN;
          pc_src_q     <= PC_NEXT;
          flush_q      <= 1'b0;
          trap_taken_q <= 1'b0;
        end

        default: begin
          state_q      <= S_RST;
          pc_src_q     <= PC_RESET;
          flush_q      <= 1'b0;
          trap_taken_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_pc_src     = pc_src_q;
  assign bus.o_pc_trap    = pc_trap_q;
  assign bus.o_mepc       = mepc_q;
  assign bus.o_mcause     = mcause_q;
  assign bus.o_mie        = mie_q;
  assign bus.o_flush      = flush_q;
  assign bus.o_trap_taken = trap_taken_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl
//   Directed bench for trap_ctrl. Each step drives EX/CSR inputs, queues the
//   output values expected after the next rising edge, and compares them once
//   the DUT has registered the result.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;

  typedef struct {
    logic [1:0]  pc_src;
    logic [31:0] pc_trap;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic        mie;
    logic        flush;
    logic        trap_taken;
  } exp_t;

`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] EXT_IRQ_TARGET = 32'h0000_032C;
  localparam logic [31:0] TMR_IRQ_TARGET = 32'h0000_031C;
`else
  localparam logic [31:0] EXT_IRQ_TARGET = 32'h0000_0300;
  localparam logic [31:0] TMR_IRQ_TARGET = 32'h0000_0300;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  exp_t e;
  exp_t sb[$];

  trap_ctrl_if #(.IRQ_W(3)) bus ();

  trap_ctrl #(
    .RESET_VEC (32'h0000_0000),
    .IRQ_W     (3)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic exp_t reset_exp();
    exp_t r;
    r.pc_src     = 2'b00;
    r.pc_trap    = 32'h0;
    r.mepc       = 32'h0;
    r.mcause     = 32'h0;
    r.mie        = 1'b0;
    r.flush      = 1'b0;
    r.trap_taken = 1'b0;
    return r;
  endfunction

  // Pop the oldest expectation and compare every output field against it
  task automatic compare_out(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      x = sb.pop_front();
      check({tag, ".pc_src"},     {30'd0, bus.o_pc_src},     {30'd0, x.pc_src});
      check({tag, ".pc_trap"},    bus.o_pc_trap,             x.pc_trap);
      check({tag, ".mepc"},       bus.o_mepc,                x.mepc);
      check({tag, ".mcause"},     bus.o_mcause,              x.mcause);
      check({tag, ".mie"},        {31'd0, bus.o_mie},        {31'd0, x.mie});
      check({tag, ".flush"},      {31'd0, bus.o_flush},      {31'd0, x.flush});
      check({tag, ".trap_taken"}, {31'd0, bus.o_trap_taken}, {31'd0, x.trap_taken});
    end
  endtask

  // Outputs right now, no clock edge
  task automatic check_now(input string tag);
    sb.push_back(e);
    compare_out(tag);
  endtask

  // Inputs already driven; compare outputs #1 after the next rising edge
  task automatic step(input string tag);
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  task automatic clear_events();
    bus.i_ex_valid    = 1'b0;
    bus.i_stall       = 1'b0;
    bus.i_ecall       = 1'b0;
    bus.i_ebreak      = 1'b0;
    bus.i_illegal     = 1'b0;
    bus.i_mret        = 1'b0;
    bus.i_irq         = 3'b000;
    bus.i_mstatus_wr  = 1'b0;
    bus.i_mstatus_mie = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    clear_events();
    bus.i_ex_pc   = 32'h0;
    bus.i_mie_en  = 3'b000;
    bus.i_mtvec   = 32'h0;

    // Reset values, including across clock edges while held
    #2;
    e = reset_exp();
    check_now("reset");
    step("reset_held");

    // Release: one more cycle of RESET select, then NEXT steady
    rst_n = 1'b1;
    check_now("rst_release");
    e.pc_src = 2'b11;
    step("run_first");
    step("run_idle");

    // ecall at 0x100 -> trap to base 0x200, cause 11
    bus.i_ex_valid = 1'b1;
    bus.i_ex_pc    = 32'h100;
    bus.i_ecall    = 1'b1;
    bus.i_mtvec    = 32'h200;
    e.pc_src = 2'b01; e.pc_trap = 32'h200; e.mepc = 32'h100; e.mcause = 32'd11;
    e.flush  = 1'b1;  e.trap_taken = 1'b1;
    step("ecall_trap");
    clear_events();
    e.pc_src = 2'b11; e.flush = 1'b0; e.trap_taken = 1'b0;
    step("ecall_back");

    // Enable MIE through the CSR path
    bus.i_mstatus_wr  = 1'b1;
    bus.i_mstatus_mie = 1'b1;
    e.mie = 1'b1;
    step("csr_mie_set");
    clear_events();

    // Timer + external pending -> external wins, cause 0x8000000B
    bus.i_mie_en   = 3'b111;
    bus.i_irq      = 3'b110;
    bus.i_ex_valid = 1'b1;
    bus.i_ex_pc    = 32'h44;
    bus.i_mtvec    = 32'h301;
    e.pc_src = 2'b01; e.pc_trap = EXT_IRQ_TARGET; e.mepc = 32'h44;
    e.mcause = 32'h8000_000B; e.mie = 1'b0; e.flush = 1'b1; e.trap_taken = 1'b1;
    step("irq_ext_trap");
    clear_events();
    e.pc_src = 2'b11; e.flush = 1'b0; e.trap_taken = 1'b0;
    step("irq_back");

    // mret restores MIE from MPIE, mepc unchanged
    bus.i_ex_valid = 1'b1;
    bus.i_ex_pc    = 32'h50;
    bus.i_mret     = 1'b1;
    e.pc_src = 2'b10; e.mie = 1'b1; e.flush = 1'b1;
    step("mret_epc");
    clear_events();
    e.pc_src = 2'b11; e.flush = 1'b0;
    step("mret_back");

    // Stalled illegal instruction is held off for 3 cycles
    bus.i_ex_valid = 1'b1;
    bus.i_ex_pc    = 32'h80;
    bus.i_illegal  = 1'b1;
    bus.i_stall    = 1'b1;
    step("stall_0");
    step("stall_1");
    step("stall_2");
    bus.i_stall = 1'b0;
    e.pc_src = 2'b01; e.pc_trap = 32'h300; e.mepc = 32'h80; e.mcause = 32'd2;
    e.mie = 1'b0; e.flush = 1'b1; e.trap_taken = 1'b1;
    step("illegal_trap");

    // Reset during S_TRAP takes effect without a clock edge
    clear_events();
    rst_n = 1'b0;
    #1;
    e = reset_exp();
    check_now("reset_in_trap");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    e.pc_src = 2'b11;
    step("rerun");

    // Interrupt + mret in EX together: interrupt wins, mepc = mret PC
    bus.i_mstatus_wr  = 1'b1;
    bus.i_mstatus_mie = 1'b1;
    e.mie = 1'b1;
    step("csr_mie_set2");
    clear_events();
    bus.i_ex_valid = 1'b1;
    bus.i_ex_pc    = 32'h60;
    bus.i_mret     = 1'b1;
    bus.i_irq      = 3'b010;
    e.pc_src = 2'b01; e.pc_trap = TMR_IRQ_TARGET; e.mepc = 32'h60;
    e.mcause = 32'h8000_0007; e.mie = 1'b0; e.flush = 1'b1; e.trap_taken = 1'b1;
    step("irq_over_mret");
    clear_events();
    e.pc_src = 2'b11; e.flush = 1'b0; e.trap_taken = 1'b0;
    step("irq_mret_back");

    // Interrupt pending with MIE=0 is ignored
    bus.i_ex_valid = 1'b1;
    bus.i_ex_pc    = 32'h64;
    bus.i_irq      = 3'b001;
    step("irq_masked");
    clear_events();

    bus.i_mstatus_wr  = 1'b1;
    bus.i_mstatus_mie = 1'b1;
    e.mie = 1'b1;
    step("csr_mie_set3");

    // ebreak + software irq + CSR write: exception wins and clears MIE
    bus.i_ex_valid = 1'b1;
    bus.i_ex_pc    = 32'h70;
    bus.i_ebreak   = 1'b1;
    bus.i_irq      = 3'b001;
    e.pc_src = 2'b01; e.pc_trap = 32'h300; e.mepc = 32'h70; e.mcause = 32'd3;
    e.mie = 1'b0; e.flush = 1'b1; e.trap_taken = 1'b1;
    step("exc_over_irq");
    clear_events();
    e.pc_src = 2'b11; e.flush = 1'b0; e.trap_taken = 1'b0;
    step("exc_back");

    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
